// File: rtl/ctrl_pipe.sv
// Pipelined MIPS control unit: ID decode plus ID/EX, EX/MEM and MEM/WB control registers
// with load-use bubbles, branch flush and external stall. Optional macro JAL_LINK_EN adds link writes.
module ctrl_pipe #(
   parameter int ALUOP_W = 3,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          instruction,
   input  logic                 stall_ext,
   input  logic                 flush,
   output logic                 id_ext_sel,
   output logic                 load_use,
   output logic [ALUOP_W+4:0]   ex_ctrl,
   output logic [3:0]           mem_ctrl,
   output logic [4:0]           mem_dst,
   output logic [1:0]           wb_ctrl,
   output logic [4:0]           wb_dst,
   output logic                 wb_link,
   output logic [CNT_W-1:0]     bubble_cnt
);

   localparam int EXW = ALUOP_W + 5;

   localparam logic [5:0] OP_RTYPE  = 6'd0;
   localparam logic [5:0] OP_REGIMM = 6'd1;
   localparam logic [5:0] OP_J      = 6'd2;
   localparam logic [5:0] OP_JAL    = 6'd3;
   localparam logic [5:0] OP_BEQ    = 6'd4;
   localparam logic [5:0] OP_BNE    = 6'd5;
   localparam logic [5:0] OP_BLEZ   = 6'd6;
   localparam logic [5:0] OP_BGTZ   = 6'd7;
   localparam logic [5:0] OP_ADDI   = 6'd8;
   localparam logic [5:0] OP_ADDIU  = 6'd9;
   localparam logic [5:0] OP_SLTI   = 6'd10;
   localparam logic [5:0] OP_SLTIU  = 6'd11;
   localparam logic [5:0] OP_ANDI   = 6'd12;
   localparam logic [5:0] OP_ORI    = 6'd13;
   localparam logic [5:0] OP_XORI   = 6'd14;
   localparam logic [5:0] OP_LUI    = 6'd15;
   localparam logic [5:0] OP_LW     = 6'd35;
   localparam logic [5:0] OP_SW     = 6'd43;
   localparam logic [5:0] FN_JR     = 6'd8;

   localparam logic [4:0] RT_BLTZ   = 5'd0;
   localparam logic [4:0] RT_BGEZ   = 5'd1;
   localparam logic [4:0] RT_BLTZAL = 5'd16;
   localparam logic [4:0] RT_BGEZAL = 5'd17;

   localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_BR    = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_RTYPE = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] ALU_XOR   = ALUOP_W'(5);
   localparam logic [ALUOP_W-1:0] ALU_LUI   = ALUOP_W'(6);
   localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(7);

   logic [5:0]          w_op;
   logic [5:0]          w_funct;
   logic [4:0]          w_rs;
   logic [4:0]          w_rt;
   logic [4:0]          w_rd;
   logic                w_unusedShamt;

   logic                w_regDst;
   logic                w_aluSrc;
   logic [ALUOP_W-1:0]  w_aluOp;
   logic [2:0]          w_azCtr;
   logic                w_jump;
   logic                w_branch;
   logic                w_memRead;
   logic                w_memWrite;
   logic                w_regWrite;
   logic                w_memtoReg;
   logic                w_extSel;
   logic                w_isBranch;
   logic                w_useRs;
   logic                w_useRt;
   logic                w_valid;
   logic                w_loadUse;
   logic [EXW-1:0]      w_idCtrl;
   logic [4:0]          w_exDst;

   logic [EXW-1:0]      r_exCtrl;
   logic [3:0]          r_exMem;
   logic [1:0]          r_exWb;
   logic [4:0]          r_exRt;
   logic [4:0]          r_exRd;
   logic [3:0]          r_memCtrl;
   logic [1:0]          r_memWb;
   logic [4:0]          r_memDst;
   logic [1:0]          r_wbCtrl;
   logic [4:0]          r_wbDst;
   logic [CNT_W-1:0]    r_bubbleCnt;

`ifdef JAL_LINK_EN
   logic                w_link;
   logic                r_exLink;
   logic                r_memLink;
   logic                r_wbLink;
`endif

   assign w_op          = instruction[31:26];
   assign w_rs          = instruction[25:21];
   assign w_rt          = instruction[20:16];
   assign w_rd          = instruction[15:11];
   assign w_funct       = instruction[5:0];
   assign w_unusedShamt = ^instruction[10:6];

   // Instruction decode; anything not recognised leaves every field at zero
   always_comb begin
      w_regDst   = 1'b0;
      w_aluSrc   = 1'b0;
      w_aluOp    = ALU_ADD;
      w_azCtr    = 3'd0;
      w_jump     = 1'b0;
      w_branch   = 1'b0;
      w_memRead  = 1'b0;
      w_memWrite = 1'b0;
      w_regWrite = 1'b0;
      w_memtoReg = 1'b0;
      w_extSel   = 1'b0;
      w_isBranch = 1'b0;
      w_useRt    = 1'b0;
      w_valid    = 1'b1;
`ifdef JAL_LINK_EN
      w_link     = 1'b0;
`endif
      case (w_op)
         OP_RTYPE: begin
            w_regDst = 1'b1;
            w_aluOp  = ALU_RTYPE;
            w_useRt  = 1'b1;
            if (w_funct == FN_JR) w_branch = 1'b1;
            else                  w_regWrite = 1'b1;
         end
         OP_LW: begin
            w_aluSrc   = 1'b1;
            w_extSel   = 1'b1;
            w_memRead  = 1'b1;
            w_regWrite = 1'b1;
            w_memtoReg = 1'b1;
         end
         OP_SW: begin
            w_aluSrc   = 1'b1;
            w_extSel   = 1'b1;
            w_memWrite = 1'b1;
            w_useRt    = 1'b1;
         end
         OP_ADDI, OP_ADDIU: begin
            w_aluSrc   = 1'b1;
            w_extSel   = 1'b1;
            w_regWrite = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            w_aluSrc   = 1'b1;
            w_extSel   = 1'b1;
            w_regWrite = 1'b1;
            w_aluOp    = (w_op == OP_ANDI) ? ALU_AND : (w_op == OP_ORI) ? ALU_OR : ALU_XOR;
         end
         OP_LUI: begin
            w_aluSrc   = 1'b1;
            w_regWrite = 1'b1;
            w_aluOp    = ALU_LUI;
         end
         OP_SLTI, OP_SLTIU: begin
            w_aluSrc   = 1'b1;
            w_extSel   = (w_op == OP_SLTI);
            w_regWrite = 1'b1;
            w_aluOp    = ALU_SLT;
         end
         OP_BEQ: begin
            w_isBranch = 1'b1;
            w_useRt    = 1'b1;
         end
         OP_BNE: begin
            w_isBranch = 1'b1;
            w_useRt    = 1'b1;
            w_azCtr    = 3'd1;
         end
         OP_BLEZ: begin
            w_isBranch = 1'b1;
            w_azCtr    = 3'd5;
         end
         OP_BGTZ: begin
            w_isBranch = 1'b1;
            w_azCtr    = 3'd2;
         end
         OP_REGIMM: begin
            w_isBranch = 1'b1;
            case (w_rt)
               RT_BLTZ: w_azCtr = 3'd4;
               RT_BGEZ: w_azCtr = 3'd6;
               RT_BLTZAL, RT_BGEZAL: begin
                  w_azCtr = (w_rt == RT_BLTZAL) ? 3'd7 : 3'd6;
`ifdef JAL_LINK_EN
                  w_regWrite = 1'b1;
                  w_link     = 1'b1;
`endif
               end
               default: begin
                  w_isBranch = 1'b0;
                  w_valid    = 1'b0;
               end
            endcase
         end
         OP_J: w_jump = 1'b1;
`ifdef JAL_LINK_EN
         OP_JAL: begin
            w_jump     = 1'b1;
            w_regWrite = 1'b1;
            w_link     = 1'b1;
         end
`endif
         default: w_valid = 1'b0;
      endcase
      if (w_isBranch) begin
         w_extSel = 1'b1;
         w_branch = 1'b1;
         w_aluOp  = ALU_BR;
      end
      w_useRs = w_valid & (w_op != OP_J) & (w_op != OP_JAL) & (w_op != OP_LUI);
   end

   assign w_idCtrl  = {w_azCtr, w_regDst, w_aluOp, w_aluSrc};
   assign w_loadUse = r_exMem[1] & (r_exRt != 5'd0) &
                      ((w_useRs & (w_rs == r_exRt)) | (w_useRt & (w_rt == r_exRt)));

`ifdef JAL_LINK_EN
   assign w_exDst = r_exLink ? 5'd31 : (r_exCtrl[ALUOP_W+1] ? r_exRd : r_exRt);
`else
   assign w_exDst = r_exCtrl[ALUOP_W+1] ? r_exRd : r_exRt;
`endif

   // ID/EX: flush beats stall; a load-use hazard swaps the decode for a bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_exCtrl <= '0;
         r_exMem  <= '0;
         r_exWb   <= '0;
         r_exRt   <= '0;
         r_exRd   <= '0;
      end else if (flush || (!stall_ext && w_loadUse)) begin
         r_exCtrl <= '0;
         r_exMem  <= '0;
         r_exWb   <= '0;
         r_exRt   <= '0;
         r_exRd   <= '0;
      end else if (!stall_ext) begin
         r_exCtrl <= w_idCtrl;
         r_exMem  <= {w_jump, w_branch, w_memRead, w_memWrite};
         r_exWb   <= {w_regWrite, w_memtoReg};
         r_exRt   <= w_valid ? w_rt : 5'd0;
         r_exRd   <= w_valid ? w_rd : 5'd0;
      end
   end

   // EX/MEM: destination resolves here, and writes to $0 are dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_memCtrl <= '0;
         r_memWb   <= '0;
         r_memDst  <= '0;
      end else if (flush) begin
         r_memCtrl <= '0;
         r_memWb   <= '0;
         r_memDst  <= '0;
      end else if (!stall_ext) begin
         r_memCtrl <= r_exMem;
         r_memWb   <= {r_exWb[1] & (w_exDst != 5'd0), r_exWb[0]};
         r_memDst  <= w_exDst;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wbCtrl <= '0;
         r_wbDst  <= '0;
      end else if (!stall_ext) begin
         r_wbCtrl <= r_memWb;
         r_wbDst  <= r_memDst;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bubbleCnt <= '0;
      end else if (!flush && !stall_ext && w_loadUse && (r_bubbleCnt != '1)) begin
         r_bubbleCnt <= r_bubbleCnt + CNT_W'(1);
      end
   end

`ifdef JAL_LINK_EN
   // Link bit follows the same hold/squash rules as the bundle it belongs to
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_exLink  <= 1'b0;
         r_memLink <= 1'b0;
         r_wbLink  <= 1'b0;
      end else begin
         if (flush || (!stall_ext && w_loadUse)) r_exLink <= 1'b0;
         else if (!stall_ext)                    r_exLink <= w_valid & w_link;
         if (flush)           r_memLink <= 1'b0;
         else if (!stall_ext) r_memLink <= r_exLink;
         if (!stall_ext)      r_wbLink  <= r_memLink;
      end
   end

   assign wb_link = r_wbLink;
`else
   assign wb_link = 1'b0;
`endif

   assign id_ext_sel = w_extSel;
   assign load_use   = w_loadUse;
   assign ex_ctrl    = r_exCtrl;
   assign mem_ctrl   = r_memCtrl;
   assign mem_dst    = r_memDst;
   assign wb_ctrl    = r_wbCtrl;
   assign wb_dst     = r_wbDst;
   assign bubble_cnt = r_bubbleCnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: instruction-level pipeline model compared every cycle,
// plus directed literal expectations. Honours JAL_LINK_EN when the design is built with it.
module tb_ctrl_pipe;

   localparam int ALUOP_W = 3;
   localparam int EXW     = ALUOP_W + 5;
   localparam logic [31:0] NOPI = 32'hFC00_0000;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       instruction;
   logic              stall_ext;
   logic              flush;

   logic              id_ext_sel, load_use, wb_link;
   logic [EXW-1:0]    ex_ctrl;
   logic [3:0]        mem_ctrl;
   logic [4:0]        mem_dst, wb_dst;
   logic [1:0]        wb_ctrl;
   logic [15:0]       bubble_cnt;

   logic              id_ext_sel2, load_use2, wb_link2;
   logic [EXW-1:0]    ex_ctrl2;
   logic [3:0]        mem_ctrl2;
   logic [4:0]        mem_dst2, wb_dst2;
   logic [1:0]        wb_ctrl2;
   logic [1:0]        bubble_cnt2;

   int passCount  = 0;
   int totalCount = 0;

   always #5 clk = ~clk;

   ctrl_pipe #(.ALUOP_W(ALUOP_W), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .instruction(instruction), .stall_ext(stall_ext), .flush(flush),
      .id_ext_sel(id_ext_sel), .load_use(load_use), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
      .mem_dst(mem_dst), .wb_ctrl(wb_ctrl), .wb_dst(wb_dst), .wb_link(wb_link),
      .bubble_cnt(bubble_cnt)
   );

   ctrl_pipe #(.ALUOP_W(ALUOP_W), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .instruction(instruction), .stall_ext(stall_ext), .flush(flush),
      .id_ext_sel(id_ext_sel2), .load_use(load_use2), .ex_ctrl(ex_ctrl2), .mem_ctrl(mem_ctrl2),
      .mem_dst(mem_dst2), .wb_ctrl(wb_ctrl2), .wb_dst(wb_dst2), .wb_link(wb_link2),
      .bubble_cnt(bubble_cnt2)
   );

   // One instruction's worth of control, tracked as it moves down the pipe
   typedef struct {
      logic [2:0] az;
      logic       regDst;
      logic [2:0] aluOp;
      logic       aluSrc;
      logic       jump, branch, memRead, memWrite, regWrite, memtoReg, link, extSel;
      logic       useRs, useRt;
      logic [4:0] rs, rt, dst;
   } slot_t;

   slot_t mEx, mMem, mWb;
   int    mCnt;

   function automatic slot_t emptySlot();
      slot_t s;
      s = '{default: 0};
      return s;
   endfunction

   function automatic slot_t decodeModel(input logic [31:0] ins);
      slot_t s;
      logic [5:0] op, fn;
      logic [4:0] rs, rt, rd;
      bit known;
      s = emptySlot();
      op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
      known = 1'b1;
      if (op == 6'd0) begin
         s.regDst = 1; s.aluOp = 3'd2; s.useRt = 1;
         if (fn == 6'd8) s.branch = 1; else s.regWrite = 1;
      end else if (op == 6'd35) begin
         s.aluSrc = 1; s.extSel = 1; s.memRead = 1; s.regWrite = 1; s.memtoReg = 1;
      end else if (op == 6'd43) begin
         s.aluSrc = 1; s.extSel = 1; s.memWrite = 1; s.useRt = 1;
      end else if (op >= 6'd8 && op <= 6'd14) begin
         s.aluSrc = 1; s.regWrite = 1; s.extSel = (op != 6'd11);
         s.aluOp = (op <= 6'd9) ? 3'd0 : (op <= 6'd11) ? 3'd7 : 3'(op - 6'd9);
      end else if (op == 6'd15) begin
         s.aluSrc = 1; s.regWrite = 1; s.aluOp = 3'd6;
      end else if (op >= 6'd4 && op <= 6'd7) begin
         s.extSel = 1; s.branch = 1; s.aluOp = 3'd1; s.useRt = (op < 6'd6);
         s.az = (op == 6'd4) ? 3'd0 : (op == 6'd5) ? 3'd1 : (op == 6'd6) ? 3'd5 : 3'd2;
      end else if (op == 6'd1) begin
         if (rt == 5'd0 || rt == 5'd1 || rt == 5'd16 || rt == 5'd17) begin
            s.extSel = 1; s.branch = 1; s.aluOp = 3'd1;
            s.az = (rt == 5'd0) ? 3'd4 : (rt == 5'd16) ? 3'd7 : 3'd6;
`ifdef JAL_LINK_EN
            if (rt[4]) begin s.regWrite = 1; s.link = 1; end
`endif
         end else known = 1'b0;
      end else if (op == 6'd2) begin
         s.jump = 1;
`ifdef JAL_LINK_EN
      end else if (op == 6'd3) begin
         s.jump = 1; s.regWrite = 1; s.link = 1;
`endif
      end else known = 1'b0;
      if (!known) return emptySlot();
      s.rs = rs;
      s.rt = rt;
      s.useRs = (op != 6'd2) && (op != 6'd3) && (op != 6'd15);
      s.dst = s.link ? 5'd31 : (s.regDst ? rd : rt);
      return s;
   endfunction

   function automatic bit modelLoadUse(input slot_t ex, input slot_t id);
      return ex.memRead && (ex.rt != 5'd0) &&
             ((id.useRs && id.rs == ex.rt) || (id.useRt && id.rt == ex.rt));
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
   endtask

   // Model advance on each clock; the pipeline empties at once on reset
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mEx = emptySlot(); mMem = emptySlot(); mWb = emptySlot(); mCnt = 0;
      end else begin
         slot_t id;
         bit    lu;
         id = decodeModel(instruction);
         lu = modelLoadUse(mEx, id);
         if (flush) begin
            if (!stall_ext) mWb = mMem;
            mMem = emptySlot();
            mEx  = emptySlot();
         end else if (!stall_ext) begin
            mWb  = mMem;
            mMem = mEx;
            mEx  = lu ? emptySlot() : id;
            if (lu) mCnt++;
         end
      end
   end

   // Every cycle out of reset, all outputs must match the model
   always @(negedge clk) begin
      if (!rst) begin
         slot_t id;
         id = decodeModel(instruction);
         checkOutput("id_ext_sel", id_ext_sel, id.extSel);
         checkOutput("load_use", load_use, modelLoadUse(mEx, id));
         checkOutput("ex_ctrl", ex_ctrl, {mEx.az, mEx.regDst, mEx.aluOp, mEx.aluSrc});
         checkOutput("mem_ctrl", mem_ctrl, {mMem.jump, mMem.branch, mMem.memRead, mMem.memWrite});
         checkOutput("mem_dst", mem_dst, mMem.dst);
         checkOutput("wb_ctrl", wb_ctrl, {mWb.regWrite && (mWb.dst != 5'd0), mWb.memtoReg});
         checkOutput("wb_dst", wb_dst, mWb.dst);
         checkOutput("wb_link", wb_link, mWb.link);
         checkOutput("bubble_cnt", bubble_cnt, (mCnt > 65535) ? 65535 : mCnt);
         checkOutput("bubble_cnt2", bubble_cnt2, (mCnt > 3) ? 3 : mCnt);
      end
   end

   function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction

   function automatic logic [31:0] jtype(input int op, input int target);
      return {6'(op), 26'(target)};
   endfunction

   task automatic applyStimulus(input logic [31:0] ins, input logic st, input logic fl);
      instruction = ins;
      stall_ext   = st;
      flush       = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   logic [31:0] tbl [0:26];

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      tbl[0]  = itype(12, 2, 3, 1);    tbl[1]  = itype(14, 3, 4, 2);
      tbl[2]  = itype(15, 0, 5, 1);    tbl[3]  = itype(10, 5, 6, 1);
      tbl[4]  = itype(11, 6, 7, 1);    tbl[5]  = itype(5, 7, 8, 2);
      tbl[6]  = itype(6, 8, 0, 2);     tbl[7]  = itype(7, 9, 0, 2);
      tbl[8]  = itype(1, 9, 0, 2);     tbl[9]  = itype(1, 9, 1, 2);
      tbl[10] = itype(1, 9, 5, 2);     tbl[11] = jtype(2, 26'h123_4567);
      tbl[12] = rtype(31, 0, 0, 8);    tbl[13] = 32'h0000_0000;
      tbl[14] = NOPI;                  tbl[15] = itype(35, 4, 11, 0);
      tbl[16] = itype(43, 11, 12, 0);  tbl[17] = itype(9, 11, 13, 4);
      tbl[18] = itype(1, 1, 17, 0);    tbl[19] = jtype(3, 26'h000_0040);
      tbl[20] = itype(35, 1, 14, 0);   tbl[21] = itype(4, 14, 0, 1);
      tbl[22] = itype(35, 1, 15, 0);   tbl[23] = itype(15, 15, 16, 0);
      tbl[24] = itype(35, 1, 16, 0);   tbl[25] = jtype(2, 26'h200_0000);
      tbl[26] = itype(13, 2, 3, 7);

      rst = 1'b0; instruction = NOPI; stall_ext = 1'b0; flush = 1'b0;
      #1 rst = 1'b1;
      #2;
      checkOutput("reset ex_ctrl", ex_ctrl, 0);
      checkOutput("reset mem_ctrl", mem_ctrl, 0);
      checkOutput("reset wb_ctrl", wb_ctrl, 0);
      checkOutput("reset bubble_cnt", bubble_cnt, 0);
      checkOutput("reset wb_link", wb_link, 0);
      tick();
      rst = 1'b0;

      // lw $2,0($1) walks the pipe
      applyStimulus(itype(35, 1, 2, 0), 0, 0);
      checkOutput("lw ext_sel", id_ext_sel, 1);
      tick();
      checkOutput("lw ex_ctrl", ex_ctrl, 8'h01);
      applyStimulus(NOPI, 0, 0);
      tick();
      checkOutput("lw mem_ctrl", mem_ctrl, 4'b0010);
      checkOutput("lw mem_dst", mem_dst, 2);
      tick();
      checkOutput("lw wb_ctrl", wb_ctrl, 2'b11);
      checkOutput("lw wb_dst", wb_dst, 2);

      // lw $3 then add $4,$3,$5: one bubble
      applyStimulus(itype(35, 1, 3, 0), 0, 0);
      tick();
      applyStimulus(rtype(3, 5, 4, 32), 0, 0);
      checkOutput("lu detect", load_use, 1);
      tick();
      checkOutput("lu bubble ex_ctrl", ex_ctrl, 0);
      checkOutput("lu bubble_cnt", bubble_cnt, 1);
      checkOutput("lu cleared", load_use, 0);
      tick();
      checkOutput("add ex_ctrl", ex_ctrl, 8'h14);

      // lw $0 then add $4,$0,$5: no hazard, write to $0 dropped
      applyStimulus(itype(35, 1, 0, 0), 0, 0);
      tick();
      applyStimulus(rtype(0, 5, 4, 32), 0, 0);
      checkOutput("lw0 no lu", load_use, 0);
      tick();
      checkOutput("lw0 mem_ctrl", mem_ctrl, 4'b0010);
      checkOutput("lw0 mem_dst", mem_dst, 0);
      applyStimulus(NOPI, 0, 0);
      tick();
      checkOutput("lw0 wb_ctrl", wb_ctrl, 2'b01);

      // stall during a load-use: hold, no bubble, then bubble on release
      applyStimulus(itype(35, 1, 3, 0), 0, 0);
      tick();
      applyStimulus(rtype(3, 5, 4, 32), 1, 0);
      checkOutput("stall lu reported", load_use, 1);
      tick();
      checkOutput("stall hold ex_ctrl", ex_ctrl, 8'h01);
      checkOutput("stall no count", bubble_cnt, 1);
      applyStimulus(rtype(3, 5, 4, 32), 0, 0);
      checkOutput("release lu", load_use, 1);
      tick();
      checkOutput("release bubble", ex_ctrl, 0);
      checkOutput("release count", bubble_cnt, 2);
      tick();
      checkOutput("release add", ex_ctrl, 8'h14);

      // flush beats load-use: squash, no count
      applyStimulus(itype(35, 1, 3, 0), 0, 0);
      tick();
      applyStimulus(rtype(3, 5, 4, 32), 0, 1);
      checkOutput("flush lu reported", load_use, 1);
      tick();
      checkOutput("flush ex_ctrl", ex_ctrl, 0);
      checkOutput("flush mem_ctrl", mem_ctrl, 0);
      checkOutput("flush no count", bubble_cnt, 2);
      applyStimulus(NOPI, 0, 0);
      tick();

      // beq in EX/MEM with flush and stall together
      applyStimulus(itype(8, 1, 7, 5), 0, 0);
      tick();
      applyStimulus(itype(4, 1, 2, 4), 0, 0);
      tick();
      applyStimulus(itype(43, 1, 9, 0), 0, 0);
      tick();
      checkOutput("beq mem_ctrl", mem_ctrl, 4'b0100);
      checkOutput("addi wb_ctrl", wb_ctrl, 2'b10);
      applyStimulus(itype(13, 1, 10, 3), 1, 1);
      tick();
      checkOutput("fs ex_ctrl", ex_ctrl, 0);
      checkOutput("fs mem_ctrl", mem_ctrl, 0);
      checkOutput("fs wb_ctrl hold", wb_ctrl, 2'b10);
      checkOutput("fs wb_dst hold", wb_dst, 7);
      applyStimulus(NOPI, 0, 0);
      tick();

      // five more load-use bubbles saturate the 2-bit counter
      for (int i = 0; i < 5; i++) begin
         applyStimulus(itype(35, 1, 3, 0), 0, 0);
         tick();
         applyStimulus(rtype(3, 5, 4, 32), 0, 0);
         tick();
         tick();
      end
      checkOutput("cnt16 after 7", bubble_cnt, 7);
      checkOutput("cnt2 saturated", bubble_cnt2, 3);

      // bltzal
      applyStimulus(itype(1, 1, 16, 3), 0, 0);
      tick();
      checkOutput("bltzal ex_ctrl", ex_ctrl, 8'hE2);
      applyStimulus(NOPI, 0, 0);
      tick();
      checkOutput("bltzal mem_ctrl", mem_ctrl, 4'b0100);
      tick();
`ifdef JAL_LINK_EN
      checkOutput("bltzal wb_ctrl", wb_ctrl, 2'b10);
      checkOutput("bltzal wb_dst", wb_dst, 31);
      checkOutput("bltzal wb_link", wb_link, 1);
`else
      checkOutput("bltzal wb_ctrl", wb_ctrl, 2'b00);
      checkOutput("bltzal wb_link", wb_link, 0);
`endif

      // jal
      applyStimulus(jtype(3, 26'h000_0040), 0, 0);
      tick();
      checkOutput("jal ex_ctrl", ex_ctrl, 0);
      applyStimulus(NOPI, 0, 0);
      tick();
`ifdef JAL_LINK_EN
      checkOutput("jal mem_ctrl", mem_ctrl, 4'b1000);
`else
      checkOutput("jal mem_ctrl", mem_ctrl, 4'b0000);
`endif
      tick();
`ifdef JAL_LINK_EN
      checkOutput("jal wb_ctrl", wb_ctrl, 2'b10);
      checkOutput("jal wb_dst", wb_dst, 31);
      checkOutput("jal wb_link", wb_link, 1);
`else
      checkOutput("jal wb_ctrl", wb_ctrl, 2'b00);
      checkOutput("jal wb_dst", wb_dst, 0);
      checkOutput("jal wb_link", wb_link, 0);
`endif

      // instruction table, plain and then with a fixed stall/flush pattern
      for (int i = 0; i < 27; i++) begin
         applyStimulus(tbl[i], 0, 0);
         tick();
      end
      for (int i = 0; i < 27; i++) begin
         applyStimulus(tbl[i], (i % 5) == 3, (i % 7) == 4);
         tick();
      end
      applyStimulus(NOPI, 0, 0);
      tick();
      tick();
      tick();

      // asynchronous reset mid-flight
      applyStimulus(itype(35, 1, 2, 0), 0, 0);
      tick();
      applyStimulus(itype(8, 1, 7, 5), 0, 0);
      tick();
      #1 rst = 1'b1;
      #1;
      checkOutput("async ex_ctrl", ex_ctrl, 0);
      checkOutput("async mem_ctrl", mem_ctrl, 0);
      checkOutput("async mem_dst", mem_dst, 0);
      checkOutput("async wb_ctrl", wb_ctrl, 0);
      checkOutput("async bubble_cnt", bubble_cnt, 0);
      tick();
      rst = 1'b0;
      applyStimulus(itype(35, 1, 2, 0), 0, 0);
      tick();
      applyStimulus(NOPI, 0, 0);
      tick();
      tick();
      checkOutput("post-reset lw wb_ctrl", wb_ctrl, 2'b11);
      tick();

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
